// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed or round-robin priority and a valid/ready output.
// One result register; a new request is captured whenever the register is empty or being drained.
module prio_encoder_rr #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in,
    input  logic         enable,
    input  logic         mode,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         out_valid,
    output logic         multi
);

    logic [W-1:0] ptr_reg;
    logic [W-1:0] fixed_win;
    logic [W-1:0] rr_win;
    logic [W-1:0] win_next;
    logic         multi_next;
    logic         accept;

    // Request vector rotated so that bit 0 corresponds to index ptr_reg.
    logic [N-1:0] rot;
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        assign rot[gi] = in[ptr_reg + W'(gi)];
    end

    always_comb begin
        fixed_win = '0;
        for (int i = 0; i < N; i++) begin
            if (in[i]) fixed_win = W'(i);
        end
    end

    // Lowest set bit of the rotated vector, mapped back to an absolute index.
    always_comb begin
        rr_win = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) rr_win = ptr_reg + W'(k);
        end
    end

    assign win_next   = mode ? rr_win : fixed_win;
    assign multi_next = (in & (in - N'(1))) != '0;
    assign accept     = enable && (in != '0) && (!out_valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y         <= '0;
            out_valid <= 1'b0;
            multi     <= 1'b0;
            ptr_reg   <= '0;
        end else if (accept) begin
            y         <= win_next;
            multi     <= multi_next;
            out_valid <= 1'b1;
            if (mode) ptr_reg <= win_next + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Randomised and directed bench for prio_encoder_rr at N=8 and N=16, checked against a
// behavioural model that searches the request vector with plain index arithmetic.
module tb_prio_encoder_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [7:0]  in8 = '0;
    logic        en8 = 1'b0, md8 = 1'b0, rdy8 = 1'b1;
    logic [2:0]  y8;
    logic        v8, m8;

    logic [15:0] in16 = '0;
    logic        en16 = 1'b0, md16 = 1'b0, rdy16 = 1'b1;
    logic [3:0]  y16;
    logic        v16, m16;

    int checks = 0;
    int passes = 0;

    // Model state, index 0 = N=8 instance, index 1 = N=16 instance.
    int m_y[2];
    int m_valid[2];
    int m_multi[2];
    int m_ptr[2];

    always #5 clk = ~clk;

    prio_encoder_rr #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .in(in8), .enable(en8), .mode(md8),
        .out_ready(rdy8), .y(y8), .out_valid(v8), .multi(m8)
    );

    prio_encoder_rr #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .in(in16), .enable(en16), .mode(md16),
        .out_ready(rdy16), .y(y16), .out_valid(v16), .multi(m16)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int highest(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int first_from(input logic [15:0] v, input int n, input int p);
        for (int k = 0; k < n; k++) if (v[(p + k) % n]) return (p + k) % n;
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_y[d] = 0; m_valid[d] = 0; m_multi[d] = 0; m_ptr[d] = 0;
        end
    endtask

    task automatic model_edge(input int d, input logic [15:0] v, input logic en,
                              input logic md, input logic rdy);
        int n;
        int w;
        n = (d == 0) ? 8 : 16;
        if (en && v != 0 && (m_valid[d] == 0 || rdy)) begin
            w = md ? first_from(v, n, m_ptr[d]) : highest(v, n);
            m_y[d] = w;
            m_multi[d] = ($countones(v) > 1) ? 1 : 0;
            m_valid[d] = 1;
            if (md) m_ptr[d] = (w + 1) % n;
        end else if (rdy) begin
            m_valid[d] = 0;
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ".y8"}, int'(y8), m_y[0]);
        check({tag, ".v8"}, int'(v8), m_valid[0]);
        check({tag, ".m8"}, int'(m8), m_multi[0]);
        check({tag, ".y16"}, int'(y16), m_y[1]);
        check({tag, ".v16"}, int'(v16), m_valid[1]);
        check({tag, ".m16"}, int'(m16), m_multi[1]);
    endtask

    // Inputs are already driven; advance one edge, update the model, compare.
    task automatic step(input string tag);
        model_edge(0, {8'h00, in8}, en8, md8, rdy8);
        model_edge(1, in16, en16, md16, rdy16);
        @(posedge clk);
        #1;
        compare(tag);
        $display("%s: in8=%h y8=%0d v8=%0b m8=%0b in16=%h y16=%0d v16=%0b m16=%0b",
                 tag, in8, y8, v8, m8, in16, y16, v16, m16);
    endtask

    task automatic drive8(input string tag, input logic [7:0] v, input logic en,
                          input logic md, input logic rdy);
        in8 = v; en8 = en; md8 = md; rdy8 = rdy;
        step(tag);
    endtask

    task automatic drive16(input string tag, input logic [15:0] v, input logic en,
                           input logic md, input logic rdy);
        in16 = v; en16 = en; md16 = md; rdy16 = rdy;
        step(tag);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #12;
        compare("reset_init");
        rst = 1'b0;
        #4;

        // Reset in the middle of a pending result clears it immediately.
        drive8("pre_rst", 8'h80, 1'b1, 1'b0, 1'b1);
        check("pre_rst_y7", int'(y8), 7);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare("async_rst");
        check("async_rst_v", int'(v8), 0);
        #1 rst = 1'b0;
        #5;
        drive8("post_rst", 8'h01, 1'b1, 1'b0, 1'b1);
        check("post_rst_y0", int'(y8), 0);

        drive8("fix_02", 8'h02, 1'b1, 1'b0, 1'b1);
        drive8("fix_80", 8'h80, 1'b1, 1'b0, 1'b1);
        drive8("fix_10", 8'h10, 1'b1, 1'b0, 1'b1);
        drive8("fix_90", 8'h90, 1'b1, 1'b0, 1'b1);
        check("fix_90_y7", int'(y8), 7);
        check("fix_90_multi", int'(m8), 1);

        // Backpressure: result 7 must stay put while a new request waits.
        drive8("bp_cap", 8'h80, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive8("bp_hold", 8'h02, 1'b1, 1'b0, 1'b0);
        check("bp_hold_y7", int'(y8), 7);
        drive8("bp_release", 8'h02, 1'b1, 1'b0, 1'b1);
        check("bp_release_y1", int'(y8), 1);

        for (int i = 0; i < 10; i++) begin
            drive8("rr_ff", 8'hFF, 1'b1, 1'b1, 1'b1);
            check("rr_ff_seq", int'(y8), i % 8);
        end
        drive8("rr_05_a", 8'h05, 1'b1, 1'b1, 1'b1);
        check("rr_05_a_y2", int'(y8), 2);
        drive8("rr_05_b", 8'h05, 1'b1, 1'b1, 1'b1);
        drive8("rr_05_c", 8'h05, 1'b1, 1'b1, 1'b1);

        drive8("noreq_a", 8'h00, 1'b1, 1'b0, 1'b1);
        drive8("noreq_b", 8'h00, 1'b1, 1'b0, 1'b1);
        drive8("noen", 8'h04, 1'b0, 1'b0, 1'b1);
        check("noen_valid", int'(v8), 0);
        en8 = 1'b0;

        drive16("w16_8000", 16'h8000, 1'b1, 1'b0, 1'b1);
        drive16("w16_0001", 16'h0001, 1'b1, 1'b0, 1'b1);
        drive16("w16_8001", 16'h8001, 1'b1, 1'b0, 1'b1);
        check("w16_8001_y15", int'(y16), 15);
        drive16("w16_rr_4000", 16'h4000, 1'b1, 1'b1, 1'b1);
        drive16("w16_rr_wrap", 16'h0001, 1'b1, 1'b1, 1'b1);
        check("w16_rr_wrap_y0", int'(y16), 0);

        for (int i = 0; i < 400; i++) begin
            in8   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            en8   = ($urandom_range(0, 5) != 0);
            md8   = $urandom_range(0, 1) != 0;
            rdy8  = ($urandom_range(0, 3) != 0);
            in16  = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            en16  = ($urandom_range(0, 5) != 0);
            md16  = $urandom_range(0, 1) != 0;
            rdy16 = ($urandom_range(0, 3) != 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
